// File: rtl/cla4_vector_writer.sv
// Exhaustive stimulus generator and response checker for a 4-bit CLA adder, streaming vectors.
// Optional STOP_ON_ERROR_EN: end the sweep after the first mismatching vector has been emitted.
module cla4_vector_writer #(
    parameter int unsigned LAST_INDEX = 511,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    output logic             dut_ci,
    input  logic [3:0]       dut_s,
    input  logic             dut_co,
    output logic [13:0]      vec_data,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic [9:0]       vec_count
);

`ifdef STOP_ON_ERROR_EN
    localparam logic StopOnErr = 1'b1;
`else
    localparam logic StopOnErr = 1'b0;
`endif

    localparam logic [8:0] LastIdx = 9'(LAST_INDEX);

    typedef enum logic [2:0] {StIdle, StDrive, StSample, StEmit, StDone} state_e;

    state_e             state_q, state_d;
    logic [8:0]         idx_q, idx_d;
    logic [3:0]         dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic               dut_ci_q, dut_ci_d;
    logic [13:0]        vec_data_q, vec_data_d;
    logic               vec_valid_q, vec_valid_d;
    logic               done_q, done_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic [4:0]         gold_sum;
    logic               mismatch;

    // idx is laid out as {A, B, Ci}, so it doubles as the top of the vector word.
    assign gold_sum = {1'b0, idx_q[8:5]} + {1'b0, idx_q[4:1]} + {4'b0, idx_q[0]};
    assign mismatch = (dut_s != gold_sum[3:0]) || (dut_co != gold_sum[4]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dut_a_d     = dut_a_q;
        dut_b_d     = dut_b_q;
        dut_ci_d    = dut_ci_q;
        vec_data_d  = vec_data_q;
        vec_valid_d = vec_valid_q;
        done_d      = done_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        stop_d      = stop_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StDrive;
                    idx_d   = '0;
                    err_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            StDrive: begin
                dut_a_d  = idx_q[8:5];
                dut_b_d  = idx_q[4:1];
                dut_ci_d = idx_q[0];
                state_d  = StSample;
            end
            StSample: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    stop_d = StopOnErr;
                end
                vec_data_d  = {idx_q, gold_sum[3:0], gold_sum[4]};
                vec_valid_d = 1'b1;
                state_d     = StEmit;
            end
            StEmit: begin
                if (vec_ready) begin
                    vec_valid_d = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                    if (idx_q == LastIdx || stop_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StDrive;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            dut_a_q     <= '0;
            dut_b_q     <= '0;
            dut_ci_q    <= 1'b0;
            vec_data_q  <= '0;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            cnt_q       <= '0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            dut_ci_q    <= dut_ci_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            stop_q      <= stop_d;
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign dut_ci    = dut_ci_q;
    assign vec_data  = vec_data_q;
    assign vec_valid = vec_valid_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign vec_count = cnt_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_cla4_vector_writer.sv
// Randomized bench for cla4_vector_writer with a behavioural (optionally faulty) adder model.
module tb_cla4_vector_writer;

`ifdef STOP_ON_ERROR_EN
    localparam bit StopMode = 1'b1;
`else
    localparam bit StopMode = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  dut_a, dut_b, dut_s;
    logic        dut_ci, dut_co;
    logic [13:0] vec_data;
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic        busy, done;
    logic [15:0] err_count;
    logic [9:0]  vec_count;

    int n_checks = 0;
    int n_fail   = 0;
    int fault_mode = 0;

    always #5 clk = ~clk;

    cla4_vector_writer #(.LAST_INDEX(511), .ERR_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_ci    (dut_ci),
        .dut_s     (dut_s),
        .dut_co    (dut_co),
        .vec_data  (vec_data),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .vec_count (vec_count)
    );

    // Adder under test: mode 0 correct, 1 S[2] stuck at 0, 2 Co inverted.
    function automatic int adder_model(input int a, input int b, input int ci, input int m);
        int sum;
        sum = a + b + ci;
        if (m == 1) sum = sum & ~4;
        if (m == 2) sum = sum ^ 16;
        return sum;
    endfunction

    always_comb begin
        int r;
        r = adder_model(int'(dut_a), int'(dut_b), int'(dut_ci), fault_mode);
        dut_s  = 4'(r % 16);
        dut_co = 1'((r / 16) % 2);
    end

    function automatic int exp_word(input int k);
        int a, b, ci, sum;
        a   = k / 32;
        b   = (k / 2) % 16;
        ci  = k % 2;
        sum = a + b + ci;
        return a * 1024 + b * 64 + ci * 32 + (sum % 16) * 2 + sum / 16;
    endfunction

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_dut_abci"}, int'({dut_a, dut_b, dut_ci}), 0);
        check_eq({tag, "_vec_data"}, int'(vec_data), 0);
        check_eq({tag, "_flags"}, int'({vec_valid, busy, done}), 0);
        check_eq({tag, "_err"}, int'(err_count), 0);
        check_eq({tag, "_vcnt"}, int'(vec_count), 0);
    endtask

    task automatic sweep(input int m, input int ready_pct, input int hold_idx,
                         input int hold_word, input int busy_start_at, input int abort_idx);
        int k, cyc, stall, n_exp, err_exp, g, f;
        logic        prev_stall;
        logic [13:0] prev_data;
        fault_mode = m;
        err_exp = 0;
        n_exp   = 512;
        for (int i = 0; i < 512; i++) begin
            g = (i / 32) + ((i / 2) % 16) + (i % 2);
            f = adder_model(i / 32, (i / 2) % 16, i % 2, m);
            if (f != g) begin
                err_exp++;
                if (StopMode && err_exp == 1) n_exp = i + 1;
            end
        end
        if (StopMode && err_exp > 0) err_exp = 1;

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_clears_counts", int'({err_count, vec_count}), 0);
        check_eq("busy_after_start", int'({busy, done}), 2);

        k = 0; cyc = 0; stall = 0; prev_stall = 1'b0; prev_data = '0;
        while (!done && cyc < 20000) begin
            if (prev_stall) check_eq("stable_word", int'({vec_valid, vec_data}),
                                     int'({1'b1, prev_data}));
            check_eq("vec_count_track", int'(vec_count), k);
            if (vec_valid && k == abort_idx) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_zero_outputs("abort");
                return;
            end
            if (vec_valid && k == hold_idx && stall < 5) begin
                check_eq("hold_word", int'(vec_data), hold_word);
                vec_ready = 1'b0;
                stall++;
            end else begin
                vec_ready = ($urandom_range(99) < ready_pct);
            end
            if (cyc == busy_start_at) start = 1'b1;
            if (vec_valid && vec_ready) begin
                check_eq("word", int'(vec_data), exp_word(k));
                k++;
            end
            prev_stall = vec_valid && !vec_ready;
            prev_data  = vec_data;
            tick();
            start = 1'b0;
            cyc++;
        end
        vec_ready = 1'b1;
        check_eq("done_reached", int'(done), 1);
        check_eq("busy_at_done", int'({busy, vec_valid}), 0);
        check_eq("err_count_end", int'(err_count), err_exp);
        check_eq("vec_count_end", int'(vec_count), n_exp);
        check_eq("words_seen", k, n_exp);
        if (ready_pct == 100 && hold_idx < 0) check_eq("sweep_cycles", cyc, 3 * n_exp);
        if (hold_idx >= 0) check_eq("hold_stalls", stall, 5);
        tick();
        check_eq("done_holds", int'({done, busy}), 2);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();
        check_zero_outputs("idle");
        sweep(0, 100, -1, 0, -1, -1);
        sweep(1, 60, -1, 0, -1, -1);
        sweep(0, 100, 3, 14'b0000_0001_1_0010_0, -1, -1);
        sweep(0, 80, -1, 0, -1, 100);
        sweep(0, 70, -1, 0, 40, -1);
        sweep(2, 100, -1, 0, 700, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
